// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit with valid/ack result handshake
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   input  logic               ack_i,
   output logic               busy_o,
   output logic               valid_o,
   output logic [2*WIDTH-1:0] result_o
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic               div_q, sa_q, sb_q, valid_q;
   logic [WIDTH-1:0]   a_q, b_q, lo_q;
   logic [WIDTH:0]     hi_q;
   logic [2*WIDTH-1:0] result_q;

   logic               accept, sa_in, sb_in, div0, neg, ge;
   logic [WIDTH-1:0]   abs_a, abs_b, quot, rem, lo_d;
   logic [WIDTH:0]     msum, rshift, rsub, hi_d;
   logic [2*WIDTH-1:0] prod, fix_d;

   // issue decode, one datapath step and the sign fix-up of the finished magnitudes
   always_comb begin
      accept = start_i & ~annul_i & ((state_q == IDLE) | ((state_q == DONE) & ack_i));
      sa_in  = op_i[0] & opdata1_i[WIDTH-1];
      sb_in  = op_i[0] & opdata2_i[WIDTH-1];
      abs_a  = sa_in ? -opdata1_i : opdata1_i;
      abs_b  = sb_in ? -opdata2_i : opdata2_i;
      div0   = op_i[1] & (opdata2_i == '0);
      msum   = hi_q + (lo_q[0] ? {1'b0, a_q} : '0);
      rshift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
      rsub   = rshift - {1'b0, b_q};
      ge     = rshift >= {1'b0, b_q};
      hi_d   = div_q ? (ge ? rsub : rshift) : {1'b0, msum[WIDTH:1]};
      lo_d   = div_q ? {lo_q[WIDTH-2:0], ge} : {msum[0], lo_q[WIDTH-1:1]};
      neg    = sa_q ^ sb_q;
      prod   = {hi_q[WIDTH-1:0], lo_q};
      quot   = neg ? -lo_q : lo_q;
      rem    = sa_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
      fix_d  = div_q ? {rem, quot} : (neg ? -prod : prod);
   end

   // control FSM and datapath registers; annul overrides everything but reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         valid_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         result_q <= '0;
      end else if (annul_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         state_q  <= div0 ? DONE : CALC;
         cnt_q    <= '0;
         div_q    <= op_i[1];
         sa_q     <= sa_in;
         sb_q     <= sb_in;
         a_q      <= abs_a;
         b_q      <= abs_b;
         hi_q     <= '0;
         lo_q     <= op_i[1] ? abs_a : abs_b;
         valid_q  <= div0;
         result_q <= div0 ? {opdata1_i, {WIDTH{1'b1}}} : result_q;
      end else begin
         case (state_q)
            CALC: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               cnt_q   <= (cnt_q == CW'(WIDTH-1)) ? '0 : cnt_q + 1'b1;
               state_q <= (cnt_q == CW'(WIDTH-1)) ? FIX : CALC;
            end
            FIX: begin
               result_q <= fix_d;
               valid_q  <= 1'b1;
               state_q  <= DONE;
            end
            DONE: begin
               valid_q <= ~ack_i;
               state_q <= ack_i ? IDLE : DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o   = (state_q == CALC) | (state_q == FIX);
   assign valid_o  = valid_q;
   assign result_o = result_q;
endmodule
